autocorr_frame: RTL
===================

AUTOCORR_FRAME -- requirements
Module: autocorr_frame

Interface
REQ-001 DW, 16, signed input sample width.
REQ-002 ORDER, 10, highest lag computed; the block produces ORDER+1 lags, R0..R[ORDER].
REQ-003 FRAME_LEN, 160, samples per analysis frame.
REQ-004 AW, 48, accumulator width; SHALL satisfy AW >= 2*DW + clog2(FRAME_LEN), checked at elaboration.
REQ-005 SHIFT, 32, arithmetic right shift applied to each accumulator before output.
REQ-006 OW, 16, signed output width.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 x_in  in  DW  signed sample.
REQ-010 x_valid  in  1  sample present.
REQ-011 x_ready  out  1  sample accepted when x_valid && x_ready.
REQ-012 abort  in  1  synchronous frame abort.
REQ-013 r_out  out  OW  signed, saturated correlation value.
REQ-014 r_lag  out  clog2(ORDER+1)  lag index of r_out.
REQ-015 r_valid  out  1  r_out/r_lag valid.
REQ-016 r_ready  in  1  consumer accepts when r_valid && r_ready.
REQ-017 r_sat  out  1  at least one lag of the current result frame saturated; qualified by r_valid.

Function
REQ-018 State machine states: IDLE, ACCUM, DRAIN, OUTPUT; x_ready SHALL be 1 in IDLE/ACCUM and 0 in DRAIN/OUTPUT.
REQ-019 IDLE->ACCUM on first accepted sample; ACCUM->DRAIN when the FRAME_LEN-th sample is accepted; DRAIN->OUTPUT after exactly 2 cycles; OUTPUT->IDLE on acceptance of lag ORDER.
REQ-020 Per accepted sample: ORDER-deep delay line d1..d[ORDER] shifts, d1 <= x_in; product p_k = x_in*d_k (d_0 = x_in) registered (stage 1), then added to acc_k (stage 2); no update on cycles without acceptance.
REQ-021 Delay line SHALL be zero at frame start, so samples before the frame contribute zero (R_k sums FRAME_LEN-k products).
REQ-022 Products are full 2*DW signed; accumulation is sign-extended to AW with no wrap (guaranteed by REQ-004).
REQ-023 r_out = clamp(acc_k >>> SHIFT) to [-2^(OW-1), 2^(OW-1)-1]; r_sat is sticky over the frame's lags and is set the cycle the clamped lag is presented.
REQ-024 OUTPUT presents lags in ascending order starting at 0; r_out/r_lag/r_valid SHALL hold stable while r_valid && !r_ready; lags are never skipped or repeated.
REQ-025 On OUTPUT->IDLE: accumulators, delay line, r_sat cleared in the same cycle; r_valid drops the cycle after the last handshake unless a new frame result is pending (it cannot be, by REQ-018).
REQ-026 abort in any state: next cycle state=IDLE, accumulators/delay line/pipeline cleared, r_valid=0; a sample presented with abort is dropped; abort has priority over all other events.
REQ-027 Latency: first r_valid 3 cycles after the cycle accepting the last frame sample.

Reset
REQ-028 While rst is high: state=IDLE, x_ready=1, r_valid=0, r_out=0, r_lag=0, r_sat=0, all accumulators, products, delay taps cleared.
REQ-029 Reset asserted mid-frame or mid-output SHALL discard the frame; the first frame after release is computed as if from power-up.

Structure
REQ-030 Package autocorr_pkg SHALL hold the state enumeration, a clog2 helper and the saturate-and-shift function.
REQ-031 One sub-module lag_mac (product register + accumulator + clear), instantiated ORDER+1 times via generate; output mux and FSM in autocorr_frame.

Verification (bench parameters: defaults except SHIFT=16)
REQ-032 Impulse: frame x[0]=16384, rest 0 -> R0=4096, R1..R10=0, r_sat=0.
REQ-033 Constant x=256 for 160 samples -> R_k=160-k (160,159,...,150), r_sat=0.
REQ-034 Alternating +256/-256 -> R_k=(-1)^k*(160-k); then x=32767 constant -> all lags 32767, r_sat=1.
REQ-035 r_ready held low 5 cycles at lag 3 -> r_out/r_lag frozen at lag 3, then lags 4..10 in order; x_ready=0 throughout OUTPUT.
REQ-036 abort at sample 50 of a random frame, then constant-256 frame -> results identical to REQ-033.
REQ-037 rst pulsed during OUTPUT at lag 5 -> r_valid=0 immediately; next constant-256 frame matches REQ-033.

Source files
------------

// File: rtl/autocorr_pkg.sv
// Shared types and helpers for the frame autocorrelator: FSM states, clog2 and the
// shift-then-clamp used to narrow each accumulator onto the output bus.
package autocorr_pkg;

    localparam int unsigned MAX_AW = 64;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StOutput
    } state_e;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                           input int unsigned shift,
                                           input int unsigned ow);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        sh    = acc >>> shift;
        hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (ow - 1));
        r.sat = 1'b0;
        r.val = sh;
        if (sh > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (sh < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lag_mac.sv
// One autocorrelation lag: registered full-width product followed by a sign-extending
// accumulator; clr wipes both and wins over any update.
module lag_mac
    import autocorr_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 mul_en,
    input  logic                 add_en,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] d_in,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod_q, prod_d;
    logic signed [AW-1:0]   acc_q, acc_d;

    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (clr) begin
            prod_d = '0;
            acc_d  = '0;
        end else begin
            if (mul_en) prod_d = (2*DW)'(x_in) * (2*DW)'(d_in);
            if (add_en) acc_d = acc_q + AW'(prod_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/autocorr_frame.sv
// Frame autocorrelator: accumulates R0..R[ORDER] over FRAME_LEN samples, then streams the
// shifted and saturated lags out in ascending order over a valid/ready handshake.
module autocorr_frame
    import autocorr_pkg::*;
#(
    parameter  int unsigned DW        = 16,
    parameter  int unsigned ORDER     = 10,
    parameter  int unsigned FRAME_LEN = 160,
    parameter  int unsigned AW        = 48,
    parameter  int unsigned SHIFT     = 32,
    parameter  int unsigned OW        = 16,
    localparam int unsigned LW        = clog2(ORDER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic                 abort,
    output logic signed [OW-1:0] r_out,
    output logic [LW-1:0]        r_lag,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic                 r_sat
);

    localparam int unsigned CW = clog2(FRAME_LEN);

    if (AW < 2 * DW + clog2(FRAME_LEN)) begin : g_aw_small
        $error("autocorr_frame: AW too narrow for DW and FRAME_LEN");
    end
    if (AW > MAX_AW) begin : g_aw_large
        $error("autocorr_frame: AW exceeds 64");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic [LW-1:0]   lag_q, lag_d;
    logic            sat_seen_q, sat_seen_d;
    logic            prod_vld_q, prod_vld_d;
    logic signed [DW-1:0] dly_q [1:ORDER];
    logic signed [DW-1:0] dly_d [1:ORDER];
    logic signed [DW-1:0] tap [ORDER+1];
    logic signed [AW-1:0] acc [ORDER+1];

    logic     accept, out_hs, last_hs, clr;
    sat_res_t res;

    assign x_ready = (state_q == StIdle) || (state_q == StAccum);
    assign accept  = x_valid && x_ready && !abort;
    assign r_valid = (state_q == StOutput);
    assign out_hs  = r_valid && r_ready && !abort;
    assign last_hs = out_hs && (lag_q == LW'(ORDER));
    // End of result streaming and abort both restart the frame from a clean slate.
    assign clr     = abort || last_hs;

    for (genvar k = 0; k <= ORDER; k++) begin : g_lag
        if (k == 0) begin : g_tap0
            assign tap[k] = x_in;
        end else begin : g_tapk
            assign tap[k] = dly_q[k];
        end
        lag_mac #(
            .DW(DW),
            .AW(AW)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .mul_en (accept),
            .add_en (prod_vld_q),
            .x_in   (x_in),
            .d_in   (tap[k]),
            .acc    (acc[k])
        );
    end

    always_comb begin
        dly_d = dly_q;
        if (clr) begin
            for (int k = 1; k <= ORDER; k++) dly_d[k] = '0;
        end else if (accept) begin
            dly_d[1] = x_in;
            for (int k = 2; k <= ORDER; k++) dly_d[k] = dly_q[k-1];
        end
    end

    always_comb begin
        res = sat_shift(64'(acc[lag_q]), SHIFT, OW);
        r_out = r_valid ? OW'(res.val) : '0;
        r_lag = lag_q;
        r_sat = r_valid && (sat_seen_q || res.sat);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        lag_d      = lag_q;
        sat_seen_d = sat_seen_q;
        prod_vld_d = clr ? 1'b0 : accept;
        if (abort) begin
            state_d    = StIdle;
            cnt_d      = '0;
            drain_d    = 1'b0;
            lag_d      = '0;
            sat_seen_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        if (cnt_q == CW'(FRAME_LEN - 1)) begin
                            state_d = StDrain;
                            cnt_d   = '0;
                        end else begin
                            state_d = StAccum;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                // Two cycles let the last product reach its accumulator.
                StDrain: begin
                    if (drain_q) begin
                        state_d = StOutput;
                        drain_d = 1'b0;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
                StOutput: begin
                    if (out_hs) begin
                        sat_seen_d = sat_seen_q | res.sat;
                        if (last_hs) begin
                            state_d    = StIdle;
                            lag_d      = '0;
                            sat_seen_d = 1'b0;
                        end else begin
                            lag_d = lag_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            lag_q      <= '0;
            sat_seen_q <= 1'b0;
            prod_vld_q <= 1'b0;
            for (int k = 1; k <= ORDER; k++) dly_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            lag_q      <= lag_d;
            sat_seen_q <= sat_seen_d;
            prod_vld_q <= prod_vld_d;
            dly_q      <= dly_d;
        end
    end

endmodule
